// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: instruction/address widths and the
// fetch beat handed from instr_fetch to decode.
package pipeline_pkg;

    localparam int DATA_WIDTH = 20;
    localparam int ADDR_WIDTH = 8;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_beat_t;

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register skid FIFO for fetch beats; entry 0 is always the head, so the
// head output is a plain register.
module fetch_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  fetch_beat_t   din,
    output fetch_beat_t   head,
    output logic [CW-1:0] count
);

    fetch_beat_t   entries      [DEPTH];
    fetch_beat_t   entries_next [DEPTH];
    logic [CW-1:0] count_next;
    logic [CW-1:0] wr_idx;

    // With a simultaneous pop the write slot moves down one place with the shift.
    always_comb begin
        entries_next = entries;
        wr_idx       = count - CW'(pop);
        count_next   = count + CW'(push) - CW'(pop);
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entries_next[i] = entries[i + 1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    entries_next[i] = din;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (clear) begin
            count <= '0;
        end else begin
            count   <= count_next;
            entries <= entries_next;
        end
    end

    assign head = entries[0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: issues reads to the synchronous instruction memory,
// buffers returned words in a skid FIFO and handles execute-stage redirects.
module instr_fetch
    import pipeline_pkg::*;
#(
    parameter int                    DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
    parameter int                    ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = pipeline_pkg::RESET_PC,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    output logic                  imem_rd_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic                  inflight;
    logic                  epoch_drop;
    logic                  issue;
    logic                  pop;
    logic                  push;
    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    fetch_beat_t           push_beat;
    fetch_beat_t           head;

    // The beat shown during a flush is void: decode is flushed in the same cycle.
    assign pop       = valid_o & ready_i & ~flush_i;
    assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    assign issue     = rst_n & en_i & ~flush_i & (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign push      = inflight & ~epoch_drop;
    assign push_beat = '{pc: resp_addr, instr: imem_rdata};

    assign imem_rd_en = issue;
    assign imem_addr  = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            resp_addr  <= '0;
            inflight   <= 1'b0;
            epoch_drop <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                resp_addr <= pc;
            end
            if (flush_i) begin
                pc         <= target_i;
                epoch_drop <= inflight;
            end else begin
                epoch_drop <= 1'b0;
                if (issue) begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (flush_i),
        .din   (push_beat),
        .head  (head),
        .count (count)
    );

    assign valid_o = (count != '0);
    assign instr_o = head.instr;
    assign pc_o    = head.pc;

endmodule
